// File: rtl/thermo_ctrl_pkg.sv
// Shared state encodings, actuator payload and FSM helper functions for the thermostat controller.
package thermo_ctrl_pkg;

  localparam int unsigned TEMP_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HEAT  = 3'd1,
    ST_COOL  = 3'd2,
    ST_DWELL = 3'd3,
    ST_FAULT = 3'd4
  } state_t;

  typedef struct packed {
    logic heater;
    logic cooler;
    logic fault;
  } act_t;

  function automatic act_t decode(state_t s);
    act_t a;
    a.heater = (s == ST_HEAT);
    a.cooler = (s == ST_COOL);
    a.fault  = (s == ST_FAULT);
    return a;
  endfunction

  // Priority: fault > mode_switch > regulation compare; dwell ignores samples.
  function automatic state_t next_state(state_t s, logic fault, logic ms, logic tv,
                                        logic lo, logic hi, logic ge, logic le,
                                        logic dwell_done);
    state_t n;
    n = s;
    case (s)
      ST_IDLE: begin
        if (fault)           n = ST_FAULT;
        else if (ms)         n = ST_IDLE;
        else if (tv && lo)   n = ST_HEAT;
        else if (tv && hi)   n = ST_COOL;
      end
      ST_HEAT: begin
        if (fault)                 n = ST_FAULT;
        else if (ms || (tv && ge)) n = ST_DWELL;
      end
      ST_COOL: begin
        if (fault)                 n = ST_FAULT;
        else if (ms || (tv && le)) n = ST_DWELL;
      end
      ST_DWELL: begin
        if (fault)           n = ST_FAULT;
        else if (dwell_done) n = ST_IDLE;
      end
      ST_FAULT: n = ST_FAULT;
      default:  n = ST_IDLE;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/thermo_cycle_timer.sv
// Free-running up-counter with synchronous clear and a terminal-count flag at LAST.
module thermo_cycle_timer #(
  parameter int unsigned W    = 8,
  parameter int unsigned LAST = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic done_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) count <= '0;
    else               count <= count + W'(1);
  end

  assign done_c = (count == W'(LAST));

endmodule

// File: rtl/thermo_ctrl_fsm.sv
// Thermostat controller: hysteresis regulation, post-activation dwell lockout and latched over-temp fault.
// Define THERMO_TIMEOUT_EN to add a sensor watchdog that faults after TIMEOUT_CYCLES without a sample.
module thermo_ctrl_fsm
  import thermo_ctrl_pkg::*;
#(
  parameter int unsigned        HYST           = 1,
  parameter int unsigned        MIN_DWELL      = 1000000,
  parameter logic [TEMP_W-1:0]  OVERTEMP       = 8'd60,
  parameter int unsigned        TIMEOUT_CYCLES = 50000000
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              temp_valid_i,
  input  logic [TEMP_W-1:0] current_temp,
  input  logic [3:0]        set_temp,
  input  logic              mode_switch,
  output logic              heater_en,
  output logic              cooler_en,
  output logic [2:0]        state_o,
  output logic              fault_o
);

  localparam int unsigned CMP_W = TEMP_W + 1;
  localparam int unsigned DW_W  = (MIN_DWELL > 1) ? $clog2(MIN_DWELL) : 1;

  state_t state;
  state_t nxt_c;
  act_t   act;

  logic [CMP_W-1:0] temp9, t9, h9;
  logic lo_c, hi_c, ge_c, le_c, overtemp_c, timeout_c, fault_c, dwell_done_c;

  // Widened compares so T-HYST / T+HYST never wrap.
  assign temp9 = CMP_W'(current_temp);
  assign t9    = CMP_W'(set_temp);
  assign h9    = CMP_W'(HYST);
  assign lo_c  = (temp9 + h9) < t9;
  assign hi_c  = temp9 > (t9 + h9);
  assign ge_c  = temp9 >= t9;
  assign le_c  = temp9 <= t9;

  assign overtemp_c = temp_valid_i && (current_temp >= OVERTEMP);

  thermo_cycle_timer #(.W(DW_W), .LAST(MIN_DWELL - 1)) u_dwell (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .clr    (state != ST_DWELL),
    .done_c (dwell_done_c)
  );

`ifdef THERMO_TIMEOUT_EN
  localparam int unsigned WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic wd_done_c;

  thermo_cycle_timer #(.W(WD_W), .LAST(TIMEOUT_CYCLES - 1)) u_watchdog (
    .clk    (clk_i),
    .rst_n  (rst_ni),
    .clr    (temp_valid_i || (state == ST_FAULT)),
    .done_c (wd_done_c)
  );

  assign timeout_c = wd_done_c && !temp_valid_i;
`else
  assign timeout_c = 1'b0;
`endif

  assign fault_c = overtemp_c || timeout_c;
  assign nxt_c   = next_state(state, fault_c, mode_switch, temp_valid_i,
                              lo_c, hi_c, ge_c, le_c, dwell_done_c);

  // State and decoded actuator outputs registered together.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= ST_IDLE;
      act   <= '0;
    end else begin
      state <= nxt_c;
      act   <= decode(nxt_c);
    end
  end

  assign heater_en = act.heater;
  assign cooler_en = act.cooler;
  assign fault_o   = act.fault;
  assign state_o   = state;

endmodule

// File: doc/thermo_ctrl_fsm.md
Name: thermo_ctrl_fsm

Overview:
- Closed-loop thermostat controller that sequences the heater and cooler actuators.
- Compares each valid sensor sample against the user set-point and applies hysteresis.
- Enforces a minimum idle dwell between actuator activations to protect the actuators.
- Sits downstream of the set-mode block (set_temp, mode_switch) and the sensor interface (current_temp plus a sample strobe); drives the actuator enables and the status LEDs.

Parameters:
- HYST, 1, hysteresis band in degrees; unsigned, 0..7.
- MIN_DWELL, 1000000, cycles both actuators stay off after either one turns off; must be at least 1.
- OVERTEMP, 8'd60, sample value at or above which the block latches FAULT.
- TIMEOUT_CYCLES, 50000000, sensor watchdog period; used only with THERMO_TIMEOUT_EN.

Ports:
- clk_i  in  1  main clock.
- rst_ni  in  1  reset; one clock, synchronous, active-low.
- temp_valid_i  in  1  one-cycle strobe; current_temp is sampled when high.
- current_temp  in  8  sensor temperature, unsigned degrees.
- set_temp  in  4  set-point from set mode, unsigned.
- mode_switch  in  1  1 = user is editing the set-point.
- heater_en  out  1  heater actuator enable.
- cooler_en  out  1  cooler actuator enable.
- state_o  out  3  current state encoding, for debug/LEDs.
- fault_o  out  1  latched fault indicator.

Behaviour:
- Reset (rst_ni=0 at a clk_i edge): state=IDLE; heater_en=0, cooler_en=0, fault_o=0; dwell counter=0; watchdog=0. Reset overrides every state, including FAULT and mid-dwell.
- All outputs are registered and decoded from the state register.
  - A temp_valid_i in cycle N changes the outputs after the edge that ends cycle N (1-cycle latency).
  - heater_en and cooler_en are never both 1.
- Arithmetic:
  - T = {4'b0, set_temp}.
  - All comparisons are done at 9 bits so that T-HYST cannot underflow and T+HYST cannot overflow.
  - lo = current_temp + HYST < T.
  - hi = current_temp > T + HYST.
- Comparisons and transitions are evaluated only in cycles with temp_valid_i=1, except dwell completion and mode_switch.
- States (state_o encoding): IDLE=0, HEAT=1, COOL=2, DWELL=3, FAULT=4.
- IDLE (both actuators off):
  - temp_valid_i and current_temp >= OVERTEMP -> FAULT.
  - Else if mode_switch=1 -> stay IDLE.
  - Else lo -> HEAT; hi -> COOL.
- HEAT (heater_en=1):
  - temp_valid_i and current_temp >= OVERTEMP -> FAULT.
  - Else (mode_switch=1) or (temp_valid_i and current_temp >= T) -> DWELL.
- COOL (cooler_en=1):
  - temp_valid_i and current_temp >= OVERTEMP -> FAULT.
  - Else (mode_switch=1) or (temp_valid_i and current_temp <= T) -> DWELL.
- DWELL (both actuators off):
  - The counter loads 0 on entry and increments every cycle.
  - At count MIN_DWELL-1 -> IDLE, so the block spends exactly MIN_DWELL cycles in DWELL.
  - An OVERTEMP sample -> FAULT immediately.
  - Samples are otherwise ignored; there is no direct DWELL->HEAT or DWELL->COOL transition.
- FAULT: both actuators off, fault_o=1; the only exit is reset.
- Priority when events coincide: OVERTEMP > mode_switch > regulation compare.
- A set_temp change while mode_switch=0 takes effect on the next valid sample.
- Boundaries:
  - set_temp=0: lo is never true.
  - set_temp=15, HYST=7: T+HYST=22; no wrap.

Optional Feature:
- Macro: THERMO_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles since the last temp_valid_i and clears on each strobe.
  - Reaching TIMEOUT_CYCLES in any non-FAULT state -> FAULT, with equal priority to OVERTEMP.
- Undefined:
  - No watchdog logic is built.
  - FAULT is reachable only via OVERTEMP.
  - TIMEOUT_CYCLES is ignored.

Decomposition:
- Package thermo_ctrl_pkg holds:
  - State encodings: ST_IDLE, ST_HEAT, ST_COOL, ST_DWELL, ST_FAULT, each 3 bits.
  - A TEMP_W=8 constant.
- One sub-module, thermo_cycle_timer:
  - Parameterised-width up-counter with clear and terminal-count output.
  - Instantiated for dwell, and a second time for the watchdog under THERMO_TIMEOUT_EN.

Test Plan (HYST=1, MIN_DWELL=4, OVERTEMP=60):
- Reset dominance: drive rst_ni=0 while in HEAT -> next edge: state_o=0, heater_en=0, cooler_en=0, fault_o=0.
- Heating cycle:
  - set_temp=10, sample 8 -> heater_en=1 one cycle later.
  - Sample 9 -> heater stays on.
  - Sample 10 -> DWELL; heater_en=0.
  - Exactly 4 cycles later -> IDLE.
- Hysteresis band and cooling:
  - set_temp=10, samples 9, 10, 11 -> remain IDLE.
  - Sample 12 -> COOL, cooler_en=1.
  - Sample 10 -> DWELL.
- Dwell lockout and mode_switch:
  - Sample 5 during DWELL -> ignored; IDLE after 4 cycles.
  - Raise mode_switch while in HEAT -> DWELL next cycle.
  - Sample 5 with mode_switch=1 in IDLE -> stays IDLE.
- Fault latch: sample 60 in COOL -> FAULT, fault_o=1, both enables 0; a later sample 10 leaves the block in FAULT until rst_ni.
- With THERMO_TIMEOUT_EN and TIMEOUT_CYCLES=20: no strobe for 20 cycles -> FAULT. Without the macro, the same stimulus stays in IDLE.
